// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants, state encoding and helpers for the RV32M multiply/divide unit
//
// Contents:
//   XLEN_DEFAULT        default operand/result width
//   OP_MUL .. OP_REMU   funct3 encodings of the M-extension operations
//   state_t             unit FSM states IDLE/CALC/FIX/DONE
//   op_is_div           funct3 -> divide-family flag
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // funct3[2] separates the divide family from the multiply family.
    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one combinational iteration of shift-add multiply or restoring divide
//
// Ports:
//   is_div    1     select restoring shift-subtract (1) or shift-add (0)
//   hi        XLEN  multiply: upper product half / divide: partial remainder
//   lo        XLEN  multiply: lower product half holding unconsumed multiplier bits
//                   divide: dividend bits being shifted out, quotient bits shifted in
//   opnd      XLEN  multiply: multiplicand magnitude / divide: divisor magnitude
//   hi_next   XLEN  hi after this iteration
//   lo_next   XLEN  lo after this iteration
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] hi,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] opnd,
    output logic [XLEN-1:0] hi_next,
    output logic [XLEN-1:0] lo_next
);

    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is set,
        // then shift the whole {carry, hi, lo} right by one.
        add_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});

        // Divide: bring the next dividend bit into the partial remainder. The
        // shifted value is below 2*divisor, so when it fits the difference is
        // below 2^XLEN and modulo subtraction is exact.
        shifted = {hi, lo[XLEN-1]};
        fits    = (shifted >= {1'b0, opnd});
        diff    = shifted[XLEN-1:0] - opnd;

        hi_next = add_sum[XLEN:1];
        lo_next = {add_sum[0], lo[XLEN-1:1]};
        if (is_div) begin
            if (fits) begin
                hi_next = diff;
                lo_next = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_next = shifted[XLEN-1:0];
                lo_next = {lo[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execution unit with pipeline stall output
//
// Ports:
//   clk_i     1     clock, rising edge
//   rst_i     1     asynchronous active-low reset
//   start_i   1     launch request, sampled in IDLE or DONE only
//   op_i      3     funct3 of the M instruction
//   src1_i    XLEN  operand A (rs1)
//   src2_i    XLEN  operand B (selected rs2)
//   flush_i   1     abort any in-flight operation; wins over start_i
//   busy_o    1     operation in progress, pipeline must stall
//   done_o    1     one-cycle pulse marking result_o valid
//   result_o  XLEN  result, held until the next accepted start
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN);

    state_t          state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;
    logic [2:0]      op_q;
    logic            neg_res;   // product or quotient must be negated
    logic            neg_rem;   // remainder must be negated

    logic [XLEN-1:0] hi_next;
    logic [XLEN-1:0] lo_next;

    // Launch-time decode of the incoming operands.
    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_result;

    always_comb begin
        a_signed = (op_i inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_signed = (op_i inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
        a_neg    = a_signed & src1_i[XLEN-1];
        b_neg    = b_signed & src2_i[XLEN-1];
        a_mag    = a_neg ? -src1_i : src1_i;
        b_mag    = b_neg ? -src2_i : src2_i;

        div_zero = op_is_div(op_i) && (src2_i == '0);
        div_ovf  = (op_i inside {OP_DIV, OP_REM})
                   && (src1_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (src2_i == '1);
        special  = div_zero | div_ovf;

        // funct3[1] picks the remainder flavour within the divide family.
        special_result = '0;
        if (div_zero) begin
            special_result = op_i[1] ? src1_i : '1;
        end else if (div_ovf) begin
            special_result = op_i[1] ? '0 : src1_i;
        end
    end

    // Sign correction and result selection for the FIX state.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        prod_fix = neg_res ? -{hi, lo} : {hi, lo};
        quot_fix = neg_res ? -lo : lo;
        rem_fix  = neg_rem ? -hi : hi;
        case (op_q)
            OP_MUL:                        fix_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = quot_fix;
            default:                       fix_result = rem_fix;
        endcase
    end

    muldiv_step #(
        .XLEN    (XLEN)
    ) u_step (
        .is_div  (op_is_div(op_q)),
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            count    <= '0;
            hi       <= '0;
            lo       <= '0;
            opnd     <= '0;
            op_q     <= OP_MUL;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            result_o <= '0;
        end else if (flush_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= IDLE;
                    if (start_i) begin
                        op_q    <= op_i;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        hi      <= '0;
                        // Multiply keeps the multiplier in lo; divide keeps the dividend there.
                        lo      <= op_is_div(op_i) ? a_mag : b_mag;
                        opnd    <= op_is_div(op_i) ? b_mag : a_mag;
                        count   <= CW'(XLEN-1);
                        if (special) begin
                            state    <= DONE;
                            done_o   <= 1'b1;
                            result_o <= special_result;
                        end else begin
                            state  <= CALC;
                            busy_o <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    hi    <= hi_next;
                    lo    <= lo_next;
                    count <= count - 1'b1;
                    if (count == '0) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result_o <= fix_result;
                    state    <= DONE;
                    busy_o   <= 1'b0;
                    done_o   <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking scoreboard bench for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN     = 32;
    localparam int LAT_NORM = XLEN + 2;
    localparam int BUSY_NORM = XLEN + 1;

    logic            clk_i   = 1'b0;
    logic            rst_i   = 1'b0;
    logic            start_i = 1'b0;
    logic [2:0]      op_i    = 3'b000;
    logic [XLEN-1:0] src1_i  = '0;
    logic [XLEN-1:0] src2_i  = '0;
    logic            flush_i = 1'b0;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] last_res;

    always #5 clk_i = ~clk_i;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Launches one op, waits for done_o (bounded), and
    // compares latency, busy cycles and the scoreboard result.
    task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit special,
                         input int pulse_at);
        int n;
        int nbusy;
        bit got;
        logic [31:0] want;
        exp_q.push_back(exp);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        op_i    = 3'($urandom);
        src1_i  = $urandom;
        src2_i  = $urandom;
        n = 0;
        nbusy = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk_i);
            n++;
            start_i = (n == pulse_at);
            if (busy_o) nbusy++;
            if (done_o) got = 1'b1;
        end
        start_i = 1'b0;
        check({tag, " latency"}, 32'(n), special ? 32'd1 : 32'(LAT_NORM));
        check({tag, " busy cycles"}, 32'(nbusy), special ? 32'd0 : 32'(BUSY_NORM));
        want = exp_q.pop_front();
        check({tag, " result"}, result_o, want);
        last_res = want;
    endtask

    // Counts done_o pulses over a window; used after an aborted op.
    task automatic expect_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (done_o) seen++;
        end
        check({tag, " stray done"}, 32'(seen), 32'd0);
    endtask

    initial begin
        last_res = '0;
        repeat (2) @(negedge clk_i);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset result", result_o, 32'h0);
        rst_i = 1'b1;
        @(negedge clk_i);

        issue("mul", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 0);
        @(negedge clk_i);
        check("mul done pulse width", 32'(done_o), 32'd0);
        check("mul busy after done", 32'(busy_o), 32'd0);
        check("mul result held", result_o, 32'hFFFFFFEB);

        issue("mulh", OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 0);
        @(negedge clk_i);
        issue("mulhu", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);
        @(negedge clk_i);
        issue("mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 1'b0, 0);
        @(negedge clk_i);
        issue("div", OP_DIV, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFD, 1'b0, 0);
        @(negedge clk_i);
        issue("rem", OP_REM, 32'hFFFFFFEC, 32'd6, 32'hFFFFFFFE, 1'b0, 0);
        @(negedge clk_i);
        issue("divu", OP_DIVU, 32'd20, 32'd6, 32'd3, 1'b0, 0);
        @(negedge clk_i);
        issue("remu", OP_REMU, 32'd20, 32'd6, 32'd2, 1'b0, 0);
        @(negedge clk_i);

        issue("divu by zero", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 0);
        @(negedge clk_i);
        issue("remu by zero", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1, 0);
        @(negedge clk_i);
        issue("div overflow", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 0);
        @(negedge clk_i);
        issue("rem overflow", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
        @(negedge clk_i);

        // Flush partway through a divide.
        start_i = 1'b1;
        op_i    = OP_DIV;
        src1_i  = 32'd100;
        src2_i  = 32'd7;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush busy", 32'(busy_o), 32'd0);
        check("flush done", 32'(done_o), 32'd0);
        check("flush result kept", result_o, last_res);
        expect_no_done("flush", 60);
        check("flush result after wait", result_o, last_res);

        // Asynchronous reset partway through a divide.
        start_i = 1'b1;
        op_i    = OP_DIVU;
        src1_i  = 32'd1000;
        src2_i  = 32'd3;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(negedge clk_i);
        check("pre-reset busy", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        #1;
        check("async reset busy", 32'(busy_o), 32'd0);
        check("async reset done", 32'(done_o), 32'd0);
        check("async reset result", result_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        expect_no_done("reset", 60);

        // Back-to-back: second start held during the DONE cycle, with a stray
        // start pulse mid-CALC carrying junk operands.
        issue("b2b first divu", OP_DIVU, 32'd20, 32'd6, 32'd3, 1'b0, 0);
        issue("b2b mul", OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, 10);
        @(negedge clk_i);
        check("b2b result held", result_o, 32'd12);
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
